hazard_scoreboard_unit: RTL and testbench

//   Responder to the decode stage's hazard-request interface. Decode presents its source

---
 rtl/hazard_scoreboard_unit.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_unit
// Description : Decode-stage hazard responder. Tracks the writers currently in
//               EX, MEM and WB in a three-entry shadow scoreboard and raises a
//               combinational stall request when the decoding instruction reads
//               a register that is still in flight. Counts stall cycles in a
//               saturating counter.
//               Build option HAZARD_FORWARDING_EN: only load-use hazards stall
//               and EX-stage operand forwarding selects are produced; without
//               it every RAW on EX/MEM stalls and the selects are tied to 00.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   mem_stall,
    input  logic                   id_two_src,
    input  logic                   id_ignore_hazard,
    input  logic [REG_ADDR_W-1:0]  id_src1,
    input  logic [REG_ADDR_W-1:0]  id_src2,
    input  logic                   id_wb_en,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   id_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_src1,
    input  logic [REG_ADDR_W-1:0]  ex_src2,
    output logic                   hazard,
    output logic [1:0]             fwd_sel1,
    output logic [1:0]             fwd_sel2,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int                     c_SB_DEPTH = 3;
    localparam logic [STALL_CNT_W-1:0] c_CNT_MAX  = {STALL_CNT_W{1'b1}};

    // Scoreboard entries: index 0 = EX, 1 = MEM, 2 = WB
    logic [c_SB_DEPTH-1:0] r_v;
    logic [c_SB_DEPTH-1:0] r_ld;
    logic [REG_ADDR_W-1:0] r_dest [c_SB_DEPTH];
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic w_hazard;
    logic w_accept;

    function automatic logic f_match(input logic                  v,
                                     input logic [REG_ADDR_W-1:0] dest,
                                     input logic [REG_ADDR_W-1:0] addr);
        return v && (dest == addr);
    endfunction

`ifdef HAZARD_FORWARDING_EN
    // Only a load sitting in EX cannot be forwarded in time
    assign w_hazard = !id_ignore_hazard && r_ld[0] &&
                      (f_match(r_v[0], r_dest[0], id_src1) ||
                       (id_two_src && f_match(r_v[0], r_dest[0], id_src2)));

    // MEM result has priority over WB data; a load in MEM has no result yet
    // and the load-use stall keeps its consumer out of EX, so it never selects 01
    assign fwd_sel1 = f_match(r_v[1] && !r_ld[1], r_dest[1], ex_src1) ? 2'b01 :
                      f_match(r_v[2], r_dest[2], ex_src1)              ? 2'b10 : 2'b00;
    assign fwd_sel2 = f_match(r_v[1] && !r_ld[1], r_dest[1], ex_src2) ? 2'b01 :
                      f_match(r_v[2], r_dest[2], ex_src2)              ? 2'b10 : 2'b00;

    logic w_unused_ok;
    assign w_unused_ok = r_ld[2];
`else
    // Full RAW interlock against EX and MEM; WB resolves through the regfile
    assign w_hazard = !id_ignore_hazard &&
                      (f_match(r_v[0], r_dest[0], id_src1) ||
                       f_match(r_v[1], r_dest[1], id_src1) ||
                       (id_two_src && (f_match(r_v[0], r_dest[0], id_src2) ||
                                       f_match(r_v[1], r_dest[1], id_src2))));

    assign fwd_sel1 = 2'b00;
    assign fwd_sel2 = 2'b00;

    logic w_unused_ok;
    assign w_unused_ok = ^{ex_src1, ex_src2, r_v[2], r_dest[2], r_ld};
`endif

    // A stalled or flushed decode slot becomes a bubble in EX
    assign w_accept    = !(w_hazard || flush);
    assign hazard      = w_hazard;
    assign stall_count = r_stall_count;

    // Advance the in-flight writers one stage; everything holds on memory wait
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int i = 0; i < c_SB_DEPTH; i++) begin
                r_dest[i] <= '0;
            end
        end else if (!mem_stall) begin
            r_v       <= {r_v[1:0], w_accept && id_wb_en};
            r_ld      <= {r_ld[1:0], w_accept && id_mem_read};
            r_dest[2] <= r_dest[1];
            r_dest[1] <= r_dest[0];
            r_dest[0] <= w_accept ? id_dest : '0;
        end
    end

    // Count effective stall cycles, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_hazard && !mem_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard_unit
// Description : Self-checking bench for hazard_scoreboard_unit. Directed
//               scenarios plus randomized traffic compared against a queue
//               model of the in-flight writers. Counter width is reduced so
//               saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_unit;

    localparam int AW   = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam int ADD_STALLS  = 0;
    localparam int LOAD_STALLS = 1;
`else
    localparam int ADD_STALLS  = 2;
    localparam int LOAD_STALLS = 2;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, mem_stall, id_two_src, id_ignore_hazard, id_wb_en, id_mem_read;
    logic [AW-1:0] id_src1, id_src2, id_dest, ex_src1, ex_src2;
    logic          hazard;
    logic [1:0]    fwd_sel1, fwd_sel2;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard_unit #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_stall(mem_stall),
        .id_two_src(id_two_src), .id_ignore_hazard(id_ignore_hazard),
        .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .id_mem_read(id_mem_read),
        .ex_src1(ex_src1), .ex_src2(ex_src2),
        .hazard(hazard), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: list of in-flight writers ----------------
    typedef struct {
        bit          v;
        bit [AW-1:0] dest;
        bit          ld;
    } wr_t;

    wr_t inflight[$];   // position = pipeline stage (0 = EX)
    int  exp_count;

    function automatic bit in_stage(input logic [AW-1:0] a, input int s);
        if (s >= inflight.size()) return 1'b0;
        return inflight[s].v && (inflight[s].dest == a);
    endfunction

    function automatic bit exp_hazard();
        if (id_ignore_hazard) return 1'b0;
`ifdef HAZARD_FORWARDING_EN
        if (inflight.size() == 0 || !inflight[0].ld) return 1'b0;
        return in_stage(id_src1, 0) || (id_two_src && in_stage(id_src2, 0));
`else
        return in_stage(id_src1, 0) || in_stage(id_src1, 1) ||
               (id_two_src && (in_stage(id_src2, 0) || in_stage(id_src2, 1)));
`endif
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] a);
`ifdef HAZARD_FORWARDING_EN
        if (in_stage(a, 1) && !inflight[1].ld) return 2'b01;
        if (in_stage(a, 2)) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        int c;
        c = exp_count;
        return c[CW-1:0];
    endfunction

    // One clock: inputs are already stable; model follows the DUT's edge
    task automatic tick();
        bit  h;
        wr_t e;
        h = exp_hazard();
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            exp_count = 0;
        end else if (!mem_stall) begin
            e.v    = !(h || flush) && id_wb_en;
            e.dest = id_dest;
            e.ld   = !(h || flush) && id_mem_read;
            inflight.push_front(e);
            if (inflight.size() > 3) void'(inflight.pop_back());
            if (h && exp_count < CMAX) exp_count++;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit wb, input logic [AW-1:0] dst, input bit ld,
                          input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input bit two, input bit ign);
        id_wb_en = wb; id_dest = dst; id_mem_read = ld;
        id_src1 = s1; id_src2 = s2; id_two_src = two; id_ignore_hazard = ign;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b0; ex_src1 = '0; ex_src2 = '0;
        set_id(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        set_id(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        ex_src1 = 4'($urandom); ex_src2 = 4'($urandom);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard act=%b exp=0", hazard); end
        checks++; if (fwd_sel1 !== 2'b00) begin failures++; $display("FAIL reset_fwd1 act=%b exp=00", fwd_sel1); end
        checks++; if (fwd_sel2 !== 2'b00) begin failures++; $display("FAIL reset_fwd2 act=%b exp=00", fwd_sel2); end
        checks++; if (stall_count !== '0) begin failures++; $display("FAIL reset_count act=%0d exp=0", stall_count); end
        // writer in flight, then reset: dependent reader must not stall
        set_id(1'b1, 4'd9, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0);
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_mid_op act=%b exp=0", hazard); end
    endtask

    task automatic test_raw();
        do_reset();
        set_id(1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);   // ADD r3
        tick();
        set_id(1'b1, 4'd8, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0);   // SUB reads r3
        for (int k = 0; k < ADD_STALLS; k++) begin
            #1;
            checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL raw_stall%0d act=%b exp=1", k, hazard); end
            tick();
        end
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL raw_release act=%b exp=0", hazard); end
        checks++; if (stall_count !== CW'(ADD_STALLS)) begin failures++; $display("FAIL raw_count act=%0d exp=%0d", stall_count, ADD_STALLS); end
    endtask

    task automatic test_two_src();
        do_reset();
        set_id(1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);   // load r5
        tick();
        set_id(1'b0, 4'd0, 1'b0, 4'd1, 4'd5, 1'b0, 1'b0);
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL two_src_off act=%b exp=0", hazard); end
        id_two_src = 1'b1;
        #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL two_src_on act=%b exp=1", hazard); end
        id_ignore_hazard = 1'b1;
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL ignore_hazard act=%b exp=0", hazard); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b1, 4'd7, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 4'd7, 4'd7, 1'b1, 1'b0);
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL flush_ex act=%b exp=0", hazard); end
        tick();
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL flush_mem act=%b exp=0", hazard); end
        checks++; if (stall_count !== '0) begin failures++; $display("FAIL flush_count act=%0d exp=0", stall_count); end
    endtask

    task automatic test_mem_stall();
        do_reset();
        set_id(1'b1, 4'd2, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);   // load r2
        tick();
        set_id(1'b0, 4'd0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL memstall_hz%0d act=%b exp=1", k, hazard); end
            checks++; if (stall_count !== '0) begin failures++; $display("FAIL memstall_cnt%0d act=%0d exp=0", k, stall_count); end
            tick();
        end
        mem_stall = 1'b0;
        for (int k = 0; k < LOAD_STALLS; k++) begin
            #1;
            checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL memstall_after%0d act=%b exp=1", k, hazard); end
            tick();
        end
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL memstall_release act=%b exp=0", hazard); end
        checks++; if (stall_count !== CW'(LOAD_STALLS)) begin failures++; $display("FAIL memstall_count act=%0d exp=%0d", stall_count, LOAD_STALLS); end
    endtask

`ifdef HAZARD_FORWARDING_EN
    task automatic test_forwarding();
        do_reset();
        set_id(1'b1, 4'd4, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);   // LDR r4
        tick();
        set_id(1'b1, 4'd10, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0);  // ADD src1=r4
        #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL ldr_use_stall act=%b exp=1", hazard); end
        tick();
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL ldr_use_release act=%b exp=0", hazard); end
        tick();
        ex_src1 = 4'd4;
        #1;
        checks++; if (fwd_sel1 !== 2'b10) begin failures++; $display("FAIL fwd_wb act=%b exp=10", fwd_sel1); end
        do_reset();
        set_id(1'b1, 4'd6, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);   // ADD r6
        tick();
        set_id(1'b1, 4'd11, 1'b0, 4'd1, 4'd6, 1'b1, 1'b0);  // SUB src2=r6
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL fwd_no_stall act=%b exp=0", hazard); end
        tick();
        ex_src1 = 4'd1; ex_src2 = 4'd6;
        #1;
        checks++; if (fwd_sel2 !== 2'b01) begin failures++; $display("FAIL fwd_mem act=%b exp=01", fwd_sel2); end
        checks++; if (fwd_sel1 !== 2'b00) begin failures++; $display("FAIL fwd_none act=%b exp=00", fwd_sel1); end
    endtask
`endif

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            set_id(1'b1, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
            tick();
            set_id(1'b0, 4'd0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
            tick();
            tick();
            tick();
        end
        #1;
        checks++; if (stall_count !== CW'(CMAX)) begin failures++; $display("FAIL saturate act=%0d exp=%0d", stall_count, CMAX); end
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b0, 4'd0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
        tick();
        #1;
        checks++; if (stall_count !== CW'(CMAX)) begin failures++; $display("FAIL saturate_hold act=%0d exp=%0d", stall_count, CMAX); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 49) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            mem_stall = ($urandom_range(0, 5) == 0);
            set_id(1'($urandom), 4'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom), ($urandom_range(0, 7) == 0));
            ex_src1 = 4'($urandom_range(0, 3));
            ex_src2 = 4'($urandom_range(0, 3));
            #1;
            checks++; if (hazard !== exp_hazard()) begin failures++; $display("FAIL rnd_hazard cyc=%0d act=%b exp=%b", k, hazard, exp_hazard()); end
            checks++; if (fwd_sel1 !== exp_fwd(ex_src1)) begin failures++; $display("FAIL rnd_fwd1 cyc=%0d act=%b exp=%b", k, fwd_sel1, exp_fwd(ex_src1)); end
            checks++; if (fwd_sel2 !== exp_fwd(ex_src2)) begin failures++; $display("FAIL rnd_fwd2 cyc=%0d act=%b exp=%b", k, fwd_sel2, exp_fwd(ex_src2)); end
            checks++; if (stall_count !== exp_cnt()) begin failures++; $display("FAIL rnd_count cyc=%0d act=%0d exp=%0d", k, stall_count, exp_cnt()); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        exp_count = 0;
        test_reset();
        test_raw();
        test_two_src();
        test_flush();
        test_mem_stall();
`ifdef HAZARD_FORWARDING_EN
        test_forwarding();
`endif
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
